beat_sequencer: RTL
===================

// Module: beat_sequencer
// PURPOSE
//  Consumes the slow beat clock produced by the tempo divider (0.3 s square wave) and
//  steps through a synchronous note ROM, one note per beat, for auto-play of a stored song.
//  Sits between the tempo divider and the tone generator; drives ROM address and note/gate.
// PARAMETERS
//  ADDR_W    6    ROM address width
//  NOTE_W    5    note code width
//  SONG_LEN  48   notes in song, 1..2**ADDR_W; last address = SONG_LEN-1
//  REST      0    note code meaning silence (gate stays low for that beat)
// PORTS
//  clk       in   1       system clock
//  rst       in   1       synchronous reset, active-high
//  beat_clk  in   1       slow beat square wave, already in clk domain (registered)
//  play      in   1       1-cycle start request
//  stop      in   1       1-cycle abort request
//  rom_addr  out  ADDR_W  note ROM address (registered)
//  rom_data  in   NOTE_W  ROM data, valid 1 clk after rom_addr changes (sync ROM)
//  note      out  NOTE_W  current note code to tone generator
//  note_on   out  1       gate: high while a non-REST note sounds
//  beat_pulse out 1       1-cycle pulse on each detected beat rising edge, any state
//  done      out  1       high in DONE state
// BEHAVIOUR
//  - Reset: state=IDLE, rom_addr=0, note=0, note_on=0, done=0, beat_d=0.
//  - Edge detect: beat_d <= beat_clk every clk; rise = beat_clk & ~beat_d;
//    beat_pulse = rise. All FSM beat actions occur at the edge where rise=1 (edge E).
//  - Priority: rst > stop > play > rise.
//  - States: IDLE, ARM, FETCH, LOAD, PLAY, DONE.
//    IDLE : rom_addr=0, note_on=0. play -> ARM.
//    ARM  : wait for rise; at E -> FETCH (rom_addr stays 0). beat_clk already high on
//           entry is NOT a beat; wait for next rising edge.
//    FETCH: one cycle (ROM captures address) -> LOAD.
//    LOAD : latch note<=rom_data; note_on<=(rom_data!=REST) -> PLAY.
//    PLAY : on rise: if rom_addr==SONG_LEN-1 -> DONE, note_on<=0;
//           else rom_addr<=rom_addr+1, note_on<=0 -> FETCH.
//    DONE : done=1, note_on=0, rom_addr holds. play -> ARM with rom_addr<=0, done<=0.
//  - Timing per beat: note_on low at E+1..E+2 (retrigger gap of 2 clk), new note and
//    gate valid after edge E+2. First note: gate rises 2 clk after the first beat in ARM.
//  - stop in any state: next edge -> IDLE, rom_addr=0, note_on=0, done=0; note keeps value.
//  - play in ARM/FETCH/LOAD/PLAY ignored. rise in IDLE/FETCH/LOAD/DONE ignored by FSM
//    (beat_pulse still asserts). Beat period >> 3 clk, so FETCH/LOAD never overlap a beat.
//  - play and stop same cycle: stop wins. rst mid-song: full reset values next edge.
//  - rom_addr never exceeds SONG_LEN-1; no wrap, song ends in DONE.
// TESTING
//  1 SONG_LEN=3, ROM={5,7,9}, play then beats every 20 clk -> note 5,7,9 each valid 2 clk
//    after beat; rom_addr 0,1,2; 4th beat -> done=1, note_on=0.
//  2 ROM[1]=REST(0) -> during beat 2 note_on stays 0, note=0; beat 3 gate returns high.
//  3 beat_clk high when play asserted -> no note until next rising edge; first gate 2 clk
//    after that edge.
//  4 stop during PLAY at rom_addr=1 -> next clk IDLE, note_on=0, rom_addr=0; later play +
//    beat restarts from address 0.
//  5 play asserted while in PLAY at addr 1 -> ignored, addr sequence unchanged; play+stop
//    same cycle in IDLE -> stays IDLE.
//  6 rst pulse mid-FETCH -> all outputs at reset values next edge; beat_pulse still
//    tracks edges in IDLE; play in DONE restarts at addr 0 with done cleared.

Source files
------------

// File: rtl/beat_sequencer.sv
// beat_sequencer: steps a synchronous note ROM one note per rising edge of the beat clock
module beat_sequencer #(
    parameter int ADDR_W   = 6,
    parameter int NOTE_W   = 5,
    parameter int SONG_LEN = 48,
    parameter int REST     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_clk,
    input  logic              play,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0] rom_data,
    output logic [NOTE_W-1:0] note,
    output logic              note_on,
    output logic              beat_pulse,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, ARM, FETCH, LOAD, PLAY, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SONG_LEN - 1);
    state_t state;
    logic   beat_d;
    logic   rise;
    assign rise       = beat_clk & ~beat_d;
    assign beat_pulse = rise;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rom_addr <= '0;
            note     <= '0;
            note_on  <= 1'b0;
            done     <= 1'b0;
            beat_d   <= 1'b0;
        end else begin
            beat_d <= beat_clk;
            if (stop) begin
                state    <= IDLE;
                rom_addr <= '0;
                note_on  <= 1'b0;
                done     <= 1'b0;
            end else begin
                case (state)
                    IDLE:  if (play) state <= ARM;
                    ARM:   if (rise) state <= FETCH;
                    FETCH: state <= LOAD;
                    LOAD: begin
                        note    <= rom_data;
                        note_on <= rom_data != NOTE_W'(REST);
                        state   <= PLAY;
                    end
                    PLAY: if (rise) begin
                        note_on <= 1'b0;
                        if (rom_addr == LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= FETCH;
                        end
                    end
                    DONE: if (play) begin
                        state    <= ARM;
                        rom_addr <= '0;
                        done     <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
